nvdla_csb_sequencer: RTL

Sequences configuration-space-bus (CSB) register accesses into the NVDLA core on behalf of the HWPE control side. Queues write/read commands, issues them one at a time on the CSB valid/ready port, and waits for the write-complete or read-data return. Optionally holds a command until the core interrupt fires. Returns one response per command, with timeout detection. Sits between the HWPE register file/controller and the NVDLA CSB pins, replacing direct single-shot CSB driving.

---
 rtl/nvdla_csb_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/nvdla_csb_sequencer.sv
// nvdla_csb_sequencer: queues CSB register commands from the HWPE control side
// and plays them into the NVDLA core one at a time. Each command can wait for
// the core interrupt first. Each command returns exactly one response, and a
// hung access becomes a timeout error response.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | no command in flight; pop the FIFO head when one is queued
// S_WAIT_INTR| command held until intr_i is sampled high
// S_ISSUE    | csb_valid_o asserted, waiting for csb_ready_i
// S_WAIT_RSP | request accepted, waiting for wr_complete / rvalid or timeout
// S_RESP     | rsp_valid_o asserted, waiting for rsp_ready_i
module nvdla_csb_sequencer #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdat_i,
  input  logic        cmd_write_i,
  input  logic        cmd_wait_intr_i,
  output logic        csb_valid_o,
  input  logic        csb_ready_i,
  output logic [15:0] csb_addr_o,
  output logic [31:0] csb_wdat_o,
  output logic        csb_write_o,
  output logic        csb_nposted_o,
  input  logic        csb_rvalid_i,
  input  logic [31:0] csb_rdata_i,
  input  logic        csb_wr_complete_i,
  input  logic        intr_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int EW = 1 + 1 + 16 + 32;

  localparam logic [AW:0]   CNT_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_INTR,
    S_ISSUE,
    S_WAIT_RSP,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // FIFO entry layout: {wait_intr, write, word address, write data}
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic [15:0]   r_cur_addr;
  logic [31:0]   r_cur_wdat;
  logic          r_cur_write;

  logic [31:0]   r_rsp_data;
  logic          r_rsp_err;
  logic [TW-1:0] r_timer;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_handshake;
  logic          w_done;
  logic          w_timeout;
  logic [EW-1:0] w_push_entry;
  logic [EW-1:0] w_head;
  logic          w_unused_addr;

  // Only the word address inside the 256 KiB CSB window reaches the core.
  assign w_unused_addr = ^{cmd_addr_i[31:18], cmd_addr_i[1:0]};

  assign w_full       = (r_count == CNT_FULL);
  assign w_empty      = (r_count == '0);
  assign w_push       = cmd_valid_i & ~w_full & ~clear_i;
  assign w_pop        = (r_state == S_IDLE) & ~w_empty & ~clear_i;
  assign w_push_entry = {cmd_wait_intr_i, cmd_write_i, cmd_addr_i[17:2], cmd_wdat_i};
  assign w_head       = r_mem[r_rd_ptr];
  assign w_handshake  = (r_state == S_ISSUE) & csb_ready_i;
  // The completion pulse that does not match the command type is ignored.
  assign w_done       = (r_state == S_WAIT_RSP) &
                        (r_cur_write ? csb_wr_complete_i : csb_rvalid_i);
  // Completion beats timeout when both land in the same cycle.
  assign w_timeout    = (r_state == S_WAIT_RSP) & ~w_done & (r_timer == TIMER_LAST);

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_entry;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; clear forces IDLE regardless of where the command was.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_nxt = w_head[EW-1] ? S_WAIT_INTR : S_ISSUE;
      end
      S_WAIT_INTR: begin
        if (intr_i) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (csb_ready_i) w_state_nxt = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        if (w_done || w_timeout) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (clear_i) w_state_nxt = S_IDLE;
  end

  // Current-command register, loaded on pop and held through the handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cur_addr  <= '0;
      r_cur_wdat  <= '0;
      r_cur_write <= 1'b0;
    end else if (w_pop) begin
      r_cur_write <= w_head[EW-2];
      r_cur_addr  <= w_head[47:32];
      r_cur_wdat  <= w_head[31:0];
    end
  end

  // Response register, loaded on completion or timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else if (!clear_i) begin
      if (w_done) begin
        r_rsp_data <= r_cur_write ? 32'h0 : csb_rdata_i;
        r_rsp_err  <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_data <= 32'h0;
        r_rsp_err  <= 1'b1;
      end
    end
  end

  // Response timer: restarts at the CSB handshake, counts while waiting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_timer <= '0;
    end else if (clear_i || w_handshake) begin
      r_timer <= '0;
    end else if (r_state == S_WAIT_RSP) begin
      r_timer <= r_timer + TIMER_ONE;
    end
  end

  assign cmd_ready_o   = ~w_full;
  assign csb_valid_o   = (r_state == S_ISSUE);
  assign csb_addr_o    = r_cur_addr;
  assign csb_wdat_o    = r_cur_wdat;
  assign csb_write_o   = r_cur_write;
  assign csb_nposted_o = 1'b1;
  assign rsp_valid_o   = (r_state == S_RESP);
  assign rsp_data_o    = r_rsp_data;
  assign rsp_err_o     = r_rsp_err;
  assign busy_o        = ~w_empty | (r_state != S_IDLE);

endmodule
